// File: rtl/search_coordinator_pkg.sv
// Shared types and sizing for the gate-sequence search coordinator.
package search_coordinator_pkg;

  localparam int SEQ_INDEX_BITS    = 4;
  localparam int HIGHEST_SEQ_INDEX = 9;
  localparam int COORD_COUNT_BITS  = 32;

  // Longest length the generator can produce; larger requests are clamped.
  localparam logic [SEQ_INDEX_BITS-1:0] MAX_SEQ_LEN = SEQ_INDEX_BITS'(HIGHEST_SEQ_INDEX + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } coord_state_t;

  function automatic logic [SEQ_INDEX_BITS-1:0] clamp_len(input logic [SEQ_INDEX_BITS-1:0] len);
    return (len > MAX_SEQ_LEN) ? MAX_SEQ_LEN : len;
  endfunction

endpackage

// File: rtl/search_coordinator_watchdog_timer.sv
// Idle-cycle watchdog: counts enabled cycles, saturates at WATCHDOG_CYCLES-1
// and reports expiry once that count is reached.
module watchdog_timer #(
  parameter int WATCHDOG_CYCLES = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(WATCHDOG_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(WATCHDOG_CYCLES - 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != LAST)) begin
      count_reg <= count_reg + CW'(1);
    end
  end

  assign expired = (count_reg == LAST);

endmodule

// File: rtl/search_coordinator.sv
// Search scheduler: sweeps sequence lengths 1..limit through the generator,
// counts scored products and stops on match, exhaustion, cancel or timeout.
module search_coordinator
  import search_coordinator_pkg::*;
#(
  parameter int COUNT_BITS      = COORD_COUNT_BITS,
  parameter int WATCHDOG_CYCLES = 4096
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      go,
  input  logic                      cancel,
  input  logic [SEQ_INDEX_BITS-1:0] len_limit,
  output logic [SEQ_INDEX_BITS-1:0] gen_max_length,
  output logic                      gen_start,
  output logic                      gen_reset,
  input  logic                      gen_complete,
  input  logic                      result_valid,
  input  logic                      result_match,
  output logic                      busy,
  output logic                      done,
  output logic                      found,
  output logic [SEQ_INDEX_BITS-1:0] found_length,
  output logic [COUNT_BITS-1:0]     eval_count,
  output logic                      timeout_err,
  output logic                      cancelled
);

  coord_state_t              state_reg;
  logic [SEQ_INDEX_BITS-1:0] cur_len_reg;
  logic [SEQ_INDEX_BITS-1:0] limit_reg;
  logic                      wd_clear;
  logic                      wd_enable;
  logic                      wd_expired;
  logic [COUNT_BITS-1:0]     eval_count_next;

  assign wd_clear        = (state_reg == START) || result_valid;
  assign wd_enable       = (state_reg == RUN) && !result_valid;
  assign eval_count_next = (eval_count == '1) ? eval_count : eval_count + COUNT_BITS'(1);

  watchdog_timer #(
    .WATCHDOG_CYCLES(WATCHDOG_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expired(wd_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      cur_len_reg    <= '0;
      limit_reg      <= '0;
      gen_max_length <= '0;
      gen_start      <= 1'b0;
      gen_reset      <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      found          <= 1'b0;
      found_length   <= '0;
      eval_count     <= '0;
      timeout_err    <= 1'b0;
      cancelled      <= 1'b0;
    end else begin
      gen_start <= 1'b0;
      gen_reset <= 1'b0;
      done      <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (go) begin
            limit_reg    <= clamp_len(len_limit);
            found        <= 1'b0;
            found_length <= '0;
            eval_count   <= '0;
            timeout_err  <= 1'b0;
            cancelled    <= 1'b0;
            cur_len_reg  <= SEQ_INDEX_BITS'(1);
            if (len_limit == '0) begin
              state_reg <= DONE;
            end else begin
              busy      <= 1'b1;
              state_reg <= START;
            end
          end
        end
        START: begin
          gen_max_length <= cur_len_reg;
          gen_start      <= 1'b1;
          state_reg      <= RUN;
        end
        RUN: begin
          if (cancel) begin
            gen_reset <= 1'b1;
            cancelled <= 1'b1;
            state_reg <= DONE;
          end else if (result_valid && result_match) begin
            eval_count   <= eval_count_next;
            found        <= 1'b1;
            found_length <= cur_len_reg;
            gen_reset    <= 1'b1;
            state_reg    <= DONE;
          end else if (gen_complete) begin
            // A product scored on the completing cycle still counts.
            if (result_valid) begin
              eval_count <= eval_count_next;
            end
            if (cur_len_reg == limit_reg) begin
              state_reg <= DONE;
            end else begin
              cur_len_reg <= cur_len_reg + SEQ_INDEX_BITS'(1);
              state_reg   <= START;
            end
          end else if (result_valid) begin
            eval_count <= eval_count_next;
          end else if (wd_expired) begin
            timeout_err <= 1'b1;
            gen_reset   <= 1'b1;
            state_reg   <= DONE;
          end
        end
        DONE: begin
          done      <= 1'b1;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
